// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// The LOCK state is only used when ARB_BURST_LOCK_EN is defined.
package fifo_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Upper bound on the requester count; sizes the one-hot helper.
  localparam int MAX_NREQ = 8;

  // One-hot vector with bit idx set. Callers truncate it to their own width.
  function automatic logic [MAX_NREQ-1:0] onehot_idx(input logic [2:0] idx);
    return {{(MAX_NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first requester after i_ptr,
// wrapping modulo NREQ. Works for non-power-of-two NREQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  // w_cand[k] is the requester visited at search step k (ptr+1+k mod NREQ).
  logic [PW-1:0]   w_cand [NREQ];
  logic [NREQ-1:0] w_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [PW:0] w_sum;
      // ptr < NREQ and step <= NREQ, so one conditional subtract wraps it.
      assign w_sum       = {1'b0, i_ptr} + (PW+1)'(gi + 1);
      assign w_cand[gi]  = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ))
                                                    : w_sum[PW-1:0];
      assign w_hit[gi]   = i_req[w_cand[gi]];
    end
  endgenerate

  // Earliest search step with an active request wins.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        o_idx = w_cand[k];
        o_any = 1'b1;
      end
    end
    o_gnt = o_any ? NREQ'(onehot_idx(3'(o_idx))) : '0;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NREQ producers.
// One registered beat per cycle; new grants stop while fifo count >= HIWATER.
// Optional burst lock: define ARB_BURST_LOCK_EN to let an owner keep the
// port for up to BURST consecutive beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DATASIZE = 8,
  parameter int FIFOSIZE = 128,
  parameter int HIWATER  = 120,
  parameter int BURST    = 4,
  parameter int CNTSIZE  = $clog2(FIFOSIZE) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ*DATASIZE-1:0] i_req_data,
  input  logic [NREQ-1:0]          i_req_v,
  output logic [NREQ-1:0]          o_req_r,
  output logic [DATASIZE-1:0]      o_fifo_din,
  output logic                     o_fifo_dinV,
  input  logic                     i_fifo_dinR,
  input  logic [CNTSIZE-1:0]       i_fifo_cnt,
  output logic [NREQ-1:0]          o_grant
);

  localparam int PW = $clog2(NREQ);
  localparam logic [CNTSIZE-1:0] HIWATER_C = CNTSIZE'(HIWATER);

  generate
    if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
      $error("fifo_wr_arbiter: NREQ must be 2..8");
    end
    if (BURST < 1) begin : g_bad_burst
      $error("fifo_wr_arbiter: BURST must be >= 1");
    end
  endgenerate

  logic [DATASIZE-1:0] r_din;
  logic                r_dinV;
  logic [NREQ-1:0]     r_grant;
  logic [PW-1:0]       r_ptr;

  logic            w_load;
  logic            w_open;
  logic            w_any;
  logic            w_accept;
  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_idx;

  // The output register can take a beat when empty or draining this cycle.
  assign w_load   = !r_dinV | i_fifo_dinR;
  assign w_open   = reset & w_load & (i_fifo_cnt < HIWATER_C);
  assign w_accept = w_open & w_any;
  assign o_req_r  = w_open ? w_gnt : '0;

`ifdef ARB_BURST_LOCK_EN
  localparam int BW = $clog2(BURST + 1);

  arb_state_t      r_state, w_state_next;
  logic [BW-1:0]   r_bcnt, w_bcnt_next;
  logic [NREQ-1:0] w_owner_oh;
  logic            w_own_v;

  // r_ptr doubles as the burst owner while locked.
  assign w_owner_oh = NREQ'(onehot_idx(3'(r_ptr)));
  assign w_own_v    = |(i_req_v & w_owner_oh);
  // While locked and the owner still has data, only the owner is eligible;
  // once it drops req_v the port is handed over in the same cycle.
  assign w_elig     = (r_state == LOCK && w_own_v) ? (i_req_v & w_owner_oh) : i_req_v;

  // Burst FSM next state: start or extend a burst on acceptance, release
  // at BURST beats or when the owner is idle on an open cycle.
  always_comb begin
    w_state_next = r_state;
    w_bcnt_next  = r_bcnt;
    if (w_accept) begin
      if (r_state == LOCK && w_own_v) begin
        w_bcnt_next = r_bcnt + BW'(1);
      end else begin
        w_bcnt_next = BW'(1);
      end
      w_state_next = (w_bcnt_next == BW'(BURST)) ? ARB : LOCK;
    end else if (w_open && r_state == LOCK) begin
      w_state_next = ARB;
    end
  end

  // Burst FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ARB;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_bcnt  <= w_bcnt_next;
    end
  end
`else
  // Every accepted beat re-runs plain round-robin arbitration.
  assign w_elig = i_req_v;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Output beat register and round-robin pointer; held while the FIFO stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_din   <= '0;
      r_dinV  <= 1'b0;
      r_grant <= '0;
      r_ptr   <= PW'(NREQ - 1);
    end else if (w_load) begin
      if (w_accept) begin
        r_din   <= i_req_data[w_idx*DATASIZE +: DATASIZE];
        r_dinV  <= 1'b1;
        r_grant <= w_gnt;
        r_ptr   <= w_idx;
      end else begin
        r_dinV  <= 1'b0;
      end
    end
  end

  assign o_fifo_din  = r_din;
  assign o_fifo_dinV = r_dinV;
  assign o_grant     = r_grant;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, DATASIZE=8).
// Burst-lock scenarios run when ARB_BURST_LOCK_EN is defined.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] req_data;
  logic [3:0]  req_v;
  logic [3:0]  req_r;
  logic [7:0]  fifo_din;
  logic        fifo_dinV;
  logic        fifo_dinR;
  logic [7:0]  fifo_cnt;
  logic [3:0]  grant;

  int checks = 0;
  int passed = 0;

  fifo_wr_arbiter #(
    .NREQ(4), .DATASIZE(8), .FIFOSIZE(128), .HIWATER(120), .BURST(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req_data  (req_data),
    .i_req_v     (req_v),
    .o_req_r     (req_r),
    .o_fifo_din  (fifo_din),
    .o_fifo_dinV (fifo_dinV),
    .i_fifo_dinR (fifo_dinR),
    .i_fifo_cnt  (fifo_cnt),
    .o_grant     (grant)
  );

  always #5 clk = ~clk;

  task automatic set_data_default();
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  endtask

  task automatic test_reset();
    reset = 1'b0; req_v = 4'hF; fifo_dinR = 1'b1; fifo_cnt = 8'd0;
    set_data_default();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (req_r !== 4'h0) $display("FAIL reset_req_r cyc=%0d got=%b want=0000", c, req_r);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (fifo_dinV !== 1'b0 || grant !== 4'h0 || fifo_din !== 8'h00)
        $display("FAIL reset_outputs cyc=%0d got dinV=%b grant=%b din=%h want 0/0000/00",
                 c, fifo_dinV, grant, fifo_din);
      else passed++;
    end
    @(negedge clk); reset = 1'b1; #1;
    checks++;
    if (req_r !== 4'b0001) $display("FAIL reset_first_req_r got=%b want=0001", req_r);
    else passed++;
    @(posedge clk); #1;
    $display("beat: req=0 din=%h grant=%b", fifo_din, grant);
    checks++;
    if (fifo_din !== 8'hA0 || fifo_dinV !== 1'b1 || grant !== 4'b0001)
      $display("FAIL reset_first_beat got din=%h dinV=%b grant=%b want A0/1/0001",
               fifo_din, fifo_dinV, grant);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    logic [7:0] exp_d;
    int idx;
    for (int k = 1; k <= 8; k++) begin
      idx = k % 4;
      exp_oh = 4'b0001 << idx;
      exp_d = 8'hA0 + 8'(idx);
      @(negedge clk); #1;
      checks++;
      if (req_r !== exp_oh) $display("FAIL rr_req_r k=%0d got=%b want=%b", k, req_r, exp_oh);
      else passed++;
      @(posedge clk); #1;
      $display("beat: req=%0d din=%h grant=%b", idx, fifo_din, grant);
      checks++;
      if (fifo_din !== exp_d || fifo_dinV !== 1'b1 || grant !== exp_oh)
        $display("FAIL rr_beat k=%0d got din=%h dinV=%b grant=%b want %h/1/%b",
                 k, fifo_din, fifo_dinV, grant, exp_d, exp_oh);
      else passed++;
    end
    @(negedge clk); req_v = 4'h0;
    @(posedge clk); #1;
    checks++;
    if (fifo_dinV !== 1'b0 || grant !== 4'b0001)
      $display("FAIL rr_idle got dinV=%b grant=%b want 0/0001", fifo_dinV, grant);
    else passed++;
  endtask

  task automatic test_single_requester();
    logic [7:0] beats [3] = '{8'h11, 8'h22, 8'h33};
    for (int b = 0; b < 3; b++) begin
      @(negedge clk); req_v = 4'b0100; req_data[23:16] = beats[b]; #1;
      checks++;
      if (req_r !== 4'b0100) $display("FAIL single_req_r b=%0d got=%b want=0100", b, req_r);
      else passed++;
      @(posedge clk); #1;
      $display("beat: req=2 din=%h grant=%b", fifo_din, grant);
      checks++;
      if (fifo_din !== beats[b] || fifo_dinV !== 1'b1 || grant !== 4'b0100)
        $display("FAIL single_beat b=%0d got din=%h dinV=%b grant=%b want %h/1/0100",
                 b, fifo_din, fifo_dinV, grant, beats[b]);
      else passed++;
    end
    @(negedge clk); req_v = 4'h0;
    @(posedge clk); #1;
    checks++;
    if (fifo_dinV !== 1'b0) $display("FAIL single_idle got dinV=%b want 0", fifo_dinV);
    else passed++;
  endtask

  task automatic test_fifo_stall();
    @(negedge clk); req_v = 4'b0001; req_data[7:0] = 8'h55; fifo_dinR = 1'b1; #1;
    checks++;
    if (req_r !== 4'b0001) $display("FAIL stall_first_req_r got=%b want=0001", req_r);
    else passed++;
    @(posedge clk); #1;
    $display("beat: req=0 din=%h grant=%b", fifo_din, grant);
    @(negedge clk); fifo_dinR = 1'b0; req_data[7:0] = 8'h66;
    for (int c = 0; c < 5; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      checks++;
      if (req_r !== 4'h0) $display("FAIL stall_req_r cyc=%0d got=%b want=0000", c, req_r);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (fifo_din !== 8'h55 || fifo_dinV !== 1'b1)
        $display("FAIL stall_hold cyc=%0d got din=%h dinV=%b want 55/1", c, fifo_din, fifo_dinV);
      else passed++;
    end
    @(negedge clk); fifo_dinR = 1'b1; #1;
    checks++;
    if (req_r !== 4'b0001) $display("FAIL stall_resume_req_r got=%b want=0001", req_r);
    else passed++;
    @(posedge clk); #1;
    $display("beat: req=0 din=%h grant=%b", fifo_din, grant);
    checks++;
    if (fifo_din !== 8'h66 || fifo_dinV !== 1'b1 || grant !== 4'b0001)
      $display("FAIL stall_next_beat got din=%h dinV=%b grant=%b want 66/1/0001",
               fifo_din, fifo_dinV, grant);
    else passed++;
    @(negedge clk); req_v = 4'h0;
    @(posedge clk); #1;
    checks++;
    if (fifo_dinV !== 1'b0) $display("FAIL stall_idle got dinV=%b want 0", fifo_dinV);
    else passed++;
  endtask

  task automatic test_watermark();
    @(negedge clk); set_data_default(); req_v = 4'hF; fifo_cnt = 8'd119; #1;
    checks++;
    if (req_r !== 4'b0010) $display("FAIL wm_open_req_r got=%b want=0010", req_r);
    else passed++;
    @(posedge clk); #1;
    $display("beat: req=1 din=%h grant=%b", fifo_din, grant);
    checks++;
    if (fifo_din !== 8'hA1 || fifo_dinV !== 1'b1)
      $display("FAIL wm_first_beat got din=%h dinV=%b want A1/1", fifo_din, fifo_dinV);
    else passed++;
    @(negedge clk); fifo_cnt = 8'd120; #1;
    checks++;
    if (req_r !== 4'h0) $display("FAIL wm_at_hiwater_req_r got=%b want=0000", req_r);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (fifo_dinV !== 1'b0 || grant !== 4'b0010)
      $display("FAIL wm_drain got dinV=%b grant=%b want 0/0010", fifo_dinV, grant);
    else passed++;
    @(negedge clk); fifo_cnt = 8'd127; #1;
    checks++;
    if (req_r !== 4'h0) $display("FAIL wm_above_req_r got=%b want=0000", req_r);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (fifo_dinV !== 1'b0) $display("FAIL wm_blocked got dinV=%b want 0", fifo_dinV);
    else passed++;
    @(negedge clk); fifo_cnt = 8'd119; #1;
    checks++;
    if (req_r !== 4'b0100) $display("FAIL wm_resume_req_r got=%b want=0100", req_r);
    else passed++;
    @(posedge clk); #1;
    $display("beat: req=2 din=%h grant=%b", fifo_din, grant);
    checks++;
    if (fifo_din !== 8'hA2 || fifo_dinV !== 1'b1 || grant !== 4'b0100)
      $display("FAIL wm_resume_beat got din=%h dinV=%b grant=%b want A2/1/0100",
               fifo_din, fifo_dinV, grant);
    else passed++;
    @(negedge clk); req_v = 4'h0; fifo_cnt = 8'd0;
    @(posedge clk); #1;
  endtask

`ifdef ARB_BURST_LOCK_EN
  task automatic test_burst_lock();
    int owners [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    logic [3:0] drop_v [7] = '{4'b0011, 4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
    int drop_o [7] = '{0, 0, 1, 1, 1, 1, 0};
    logic [3:0] exp_oh;
    @(negedge clk); reset = 1'b0; req_v = 4'h0; set_data_default();
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k != 0) @(negedge clk);
      req_v = 4'b0011; #1;
      exp_oh = 4'b0001 << owners[k];
      checks++;
      if (req_r !== exp_oh) $display("FAIL lock_req_r k=%0d got=%b want=%b", k, req_r, exp_oh);
      else passed++;
      @(posedge clk); #1;
      $display("beat: req=%0d din=%h grant=%b", owners[k], fifo_din, grant);
      checks++;
      if (grant !== exp_oh || fifo_din !== 8'hA0 + 8'(owners[k]))
        $display("FAIL lock_beat k=%0d got grant=%b din=%h want %b", k, grant, fifo_din, exp_oh);
      else passed++;
    end
    @(negedge clk); reset = 1'b0; req_v = 4'h0;
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k != 0) @(negedge clk);
      req_v = drop_v[k]; #1;
      exp_oh = 4'b0001 << drop_o[k];
      checks++;
      if (req_r !== exp_oh) $display("FAIL drop_req_r k=%0d got=%b want=%b", k, req_r, exp_oh);
      else passed++;
      @(posedge clk); #1;
      $display("beat: req=%0d din=%h grant=%b", drop_o[k], fifo_din, grant);
    end
    @(negedge clk); req_v = 4'h0;
    @(posedge clk); #1;
  endtask
`else
  task automatic test_two_requesters();
    logic [3:0] exp_oh;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); req_v = 4'b0011; #1;
      exp_oh = 4'b0001 << (k % 2);
      checks++;
      if (req_r !== exp_oh) $display("FAIL alt_req_r k=%0d got=%b want=%b", k, req_r, exp_oh);
      else passed++;
      @(posedge clk); #1;
      $display("beat: req=%0d din=%h grant=%b", k % 2, fifo_din, grant);
      checks++;
      if (grant !== exp_oh || fifo_din !== 8'hA0 + 8'(k % 2))
        $display("FAIL alt_beat k=%0d got grant=%b din=%h want %b", k, grant, fifo_din, exp_oh);
      else passed++;
    end
    @(negedge clk); req_v = 4'h0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single_requester();
    test_fifo_stall();
    test_watermark();
`ifdef ARB_BURST_LOCK_EN
    test_burst_lock();
`else
    test_two_requesters();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
